// File: rtl/seg_scan_rx.sv
// rtl/seg_scan_rx.sv - six-digit seven-segment scan bus receiver
// Settles each one-cold digit slot, decodes it back to BCD and publishes full frames.
module seg_scan_rx #(
    parameter int SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_frame_err,
    output logic        o_enb_err
);

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYC);

    logic [6:0]  r_seg;
    logic        r_dp;
    logic [5:0]  r_enb;
    logic [5:0]  prev_enb;
    logic [7:0]  stable_cnt;
    logic        sampled;
    logic [23:0] shadow;
    logic [5:0]  shadow_dp;
    logic [5:0]  seen;
    logic        err_acc;

    logic [2:0]  zero_cnt;
    logic [2:0]  slot;
    logic        enb_legal;
    logic        enb_idle;
    logic        enb_same;
    logic        capture;
    logic        frame_done;
    logic [3:0]  dec;
    logic [5:0]  seen_next;
    logic        err_next;

    always_comb begin
        zero_cnt = 3'd0;
        slot     = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!r_enb[i]) begin
                zero_cnt = zero_cnt + 3'd1;
                slot     = 3'(i);
            end
        end
        enb_legal = (zero_cnt == 3'd1);
        enb_idle  = (r_enb == 6'h3F);
        enb_same  = (r_enb == prev_enb);
        // Gating on enb_same keeps a saturated count from leaking into the next slot.
        capture   = enb_legal && enb_same && (stable_cnt == SETTLE) && !sampled;
    end

    always_comb begin
        case (r_seg)
            7'b1111110: dec = 4'h0;
            7'b0110000: dec = 4'h1;
            7'b1101101: dec = 4'h2;
            7'b1111001: dec = 4'h3;
            7'b0110011: dec = 4'h4;
            7'b1011011: dec = 4'h5;
            7'b1011111: dec = 4'h6;
            7'b1110000: dec = 4'h7;
            7'b1111111: dec = 4'h8;
            7'b1110011: dec = 4'h9;
            7'b0000000: dec = 4'hF;
            default:    dec = 4'hE;
        endcase
    end

    // A capture coinciding with frame completion lands in the freshly cleared mask.
    always_comb begin
        frame_done = (seen == 6'h3F);
        seen_next  = frame_done ? 6'h00 : seen;
        err_next   = frame_done ? 1'b0 : err_acc;
        if (capture) begin
            seen_next = seen_next | (6'b000001 << slot);
            err_next  = err_next | (dec == 4'hE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg       <= 7'd0;
            r_dp        <= 1'b0;
            r_enb       <= 6'h3F;
            prev_enb    <= 6'h3F;
            stable_cnt  <= 8'd0;
            sampled     <= 1'b0;
            shadow      <= 24'hFFFFFF;
            shadow_dp   <= 6'd0;
            seen        <= 6'd0;
            err_acc     <= 1'b0;
            o_digits    <= 24'hFFFFFF;
            o_dp        <= 6'd0;
            o_frame_vld <= 1'b0;
            o_frame_err <= 1'b0;
            o_enb_err   <= 1'b0;
        end else begin
            r_seg     <= i_seg;
            r_dp      <= i_seg_dp;
            r_enb     <= i_seg_enb;
            prev_enb  <= r_enb;
            o_enb_err <= !enb_legal && !enb_idle;

            if (!enb_legal) begin
                stable_cnt <= 8'd0;
                sampled    <= 1'b0;
            end else if (!enb_same) begin
                stable_cnt <= 8'd1;
                sampled    <= 1'b0;
            end else begin
                if (stable_cnt < SETTLE)
                    stable_cnt <= stable_cnt + 8'd1;
                if (capture)
                    sampled <= 1'b1;
            end

            if (capture) begin
                shadow[4*slot +: 4] <= dec;
                shadow_dp[slot]     <= r_dp;
            end
            seen    <= seen_next;
            err_acc <= err_next;

            o_frame_vld <= frame_done;
            o_frame_err <= frame_done && err_acc;
            if (frame_done) begin
                o_digits <= shadow;
                o_dp     <= shadow_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb/tb_seg_scan_rx.sv - directed self-checking bench for seg_scan_rx
module tb_seg_scan_rx;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
    localparam logic [6:0] S7 = 7'b1110000, S8 = 7'b1111111, S9 = 7'b1110011;
    localparam logic [6:0] SB = 7'b0000000, SX = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  i_seg = 7'd0;
    logic        i_seg_dp = 1'b0;
    logic [5:0]  i_seg_enb = 6'h3F;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_vld;
    logic        o_frame_err;
    logic        o_enb_err;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int enb_cnt  = 0;
    int wide_cnt = 0;
    logic        prev_vld = 1'b0;
    logic [23:0] frame_dig [0:31];
    logic        frame_err [0:31];
    logic [5:0]  frame_dp  [0:31];
    int base_vld, base_enb, base_wide;

    seg_scan_rx #(.SETTLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_seg       (i_seg),
        .i_seg_dp    (i_seg_dp),
        .i_seg_enb   (i_seg_enb),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_frame_vld (o_frame_vld),
        .o_frame_err (o_frame_err),
        .o_enb_err   (o_enb_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_frame_vld) begin
            frame_dig[vld_cnt % 32] = o_digits;
            frame_err[vld_cnt % 32] = o_frame_err;
            frame_dp[vld_cnt % 32]  = o_dp;
            vld_cnt = vld_cnt + 1;
            if (prev_vld)
                wide_cnt = wide_cnt + 1;
        end
        if (o_enb_err)
            enb_cnt = enb_cnt + 1;
        prev_vld = o_frame_vld;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slot(input int k, input logic [6:0] seg, input logic dp, input int n);
        i_seg_enb = ~(6'b000001 << k);
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_seg_enb = 6'h3F;
        i_seg     = 7'd0;
        i_seg_dp  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        base_vld  = vld_cnt;
        base_enb  = enb_cnt;
        base_wide = wide_cnt;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(o_digits), 32'hFFFFFF);
        check("rst_dp", 32'(o_dp), 32'h0);
        check("rst_vld", 32'(o_frame_vld), 32'h0);
        check("rst_ferr", 32'(o_frame_err), 32'h0);
        check("rst_enberr", 32'(o_enb_err), 32'h0);
        rst = 1'b0;
        idle(3);

        // Ordered scan, slots 0/1 carry 1/0, rest blank
        mark();
        slot(0, S1, 0, 10); slot(1, S0, 0, 10);
        for (int k = 2; k < 6; k++) slot(k, SB, 0, 10);
        idle(6);
        check("t1_vld_cnt", 32'(vld_cnt - base_vld), 32'd1);
        check("t1_digits", 32'(frame_dig[base_vld % 32]), 32'hFFFF01);
        check("t1_dp", 32'(frame_dp[base_vld % 32]), 32'h0);
        check("t1_ferr", 32'(frame_err[base_vld % 32]), 32'h0);
        check("t1_hold", 32'(o_digits), 32'hFFFF01);

        // Undecodable slot 3, dp on slot 5
        mark();
        slot(0, S1, 0, 10); slot(1, S0, 0, 10); slot(2, SB, 0, 10);
        slot(3, SX, 0, 10); slot(4, SB, 0, 10); slot(5, SB, 1, 10);
        idle(6);
        check("t2_vld_cnt", 32'(vld_cnt - base_vld), 32'd1);
        check("t2_digits", 32'(frame_dig[base_vld % 32]), 32'hFFEF01);
        check("t2_ferr", 32'(frame_err[base_vld % 32]), 32'h1);
        check("t2_dp", 32'(frame_dp[base_vld % 32]), 32'h20);

        // Short slot-2 dwell must not capture
        mark();
        slot(0, S1, 0, 10); slot(1, S0, 0, 10); slot(2, S2, 0, 3);
        slot(3, SB, 0, 10); slot(4, SB, 0, 10); slot(5, SB, 0, 10);
        idle(6);
        check("t3_no_vld", 32'(vld_cnt - base_vld), 32'd0);
        slot(2, S2, 0, 10);
        idle(6);
        check("t3_vld_cnt", 32'(vld_cnt - base_vld), 32'd1);
        check("t3_digits", 32'(frame_dig[base_vld % 32]), 32'hFFF201);
        check("t3_ferr", 32'(frame_err[base_vld % 32]), 32'h0);

        // Illegal enable value for two cycles mid-scan
        mark();
        slot(0, S1, 0, 10); slot(1, S0, 0, 10);
        i_seg_enb = 6'b111100; i_seg = S8;
        repeat (2) @(negedge clk);
        slot(2, S7, 0, 10);
        for (int k = 3; k < 6; k++) slot(k, SB, 0, 10);
        idle(6);
        check("t4_enb_err", 32'(enb_cnt - base_enb), 32'd2);
        check("t4_vld_cnt", 32'(vld_cnt - base_vld), 32'd1);
        check("t4_digits", 32'(frame_dig[base_vld % 32]), 32'hFFF701);

        // Reset mid-frame discards partial captures
        mark();
        slot(0, S8, 1, 10); slot(1, S8, 1, 10); slot(2, S8, 1, 10); slot(3, S8, 1, 10);
        rst = 1'b1;
        idle(3);
        check("t5_rst_digits", 32'(o_digits), 32'hFFFFFF);
        check("t5_rst_dp", 32'(o_dp), 32'h0);
        rst = 1'b0;
        idle(2);
        slot(0, S3, 0, 10); slot(1, S4, 0, 10);
        for (int k = 2; k < 6; k++) slot(k, SB, 0, 10);
        idle(6);
        check("t5_vld_cnt", 32'(vld_cnt - base_vld), 32'd1);
        check("t5_digits", 32'(frame_dig[base_vld % 32]), 32'hFFFF43);
        check("t5_dp", 32'(frame_dp[base_vld % 32]), 32'h0);

        // Two back-to-back frames, 59 then 00
        mark();
        slot(0, S9, 0, 10); slot(1, S5, 0, 10);
        for (int k = 2; k < 6; k++) slot(k, SB, 0, 10);
        slot(0, S0, 0, 10); slot(1, S0, 0, 10);
        for (int k = 2; k < 6; k++) slot(k, SB, 0, 10);
        idle(6);
        check("t6_vld_cnt", 32'(vld_cnt - base_vld), 32'd2);
        check("t6_first", 32'(frame_dig[base_vld % 32]), 32'hFFFF59);
        check("t6_second", 32'(frame_dig[(base_vld + 1) % 32]), 32'hFFFF00);
        check("t6_out_hold", 32'(o_digits[7:0]), 32'h00);
        check("vld_width", 32'(wide_cnt), 32'd0);
        check("no_stray_enb_err", 32'(enb_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
Receiver for the multiplexed six-digit seven-segment scan bus. It watches the shared segment lines, the decimal-point line and the one-cold digit enables, then waits for each digit slot to settle. Each settled slot is decoded back to a BCD digit and a decimal-point bit. Once all six positions have been captured, the block publishes a coherent frame. It serves as the bus monitor in display benches and as the readback path for self-check logic.

Parameters:
SETTLE_CYC, 4, consecutive cycles an enable value must hold before its slot is sampled (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high
i_seg_dp  input  1  decimal-point line of the currently enabled digit
i_seg_enb  input  6  digit enables, active-low one-cold; bit k selects position k
o_digits  output  24  decoded frame, position k at [4k+3:4k]; 4'hF = blank, 4'hE = undecodable
o_dp  output  6  decoded decimal points, bit k = position k
o_frame_vld  output  1  one-cycle pulse when o_digits/o_dp update
o_frame_err  output  1  valid with o_frame_vld; 1 if any position in the frame was 4'hE
o_enb_err  output  1  one-cycle pulse on each illegal enable value

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values: o_digits=24'hFFFFFF, o_dp=6'b000000, o_frame_vld=0, o_frame_err=0, o_enb_err=0. Internal state clears: shadow digits 4'hF, seen mask 0, stable counter 0, sampled flag 0.
- Input stage: i_seg, i_seg_dp and i_seg_enb are registered once. All logic below uses the registered values (r_*).
- Enable classification of r_enb:
  - exactly one bit 0 -> legal slot k;
  - all ones -> idle;
  - any other value -> illegal.
- Illegal r_enb: o_enb_err pulses 1 cycle. Stable counter and sampled flag clear, and no capture occurs. The seen mask is retained.
- Idle: stable counter and sampled flag clear. No error is raised.
- Settling:
  - When r_enb differs from its previous-cycle value, the stable counter loads 1 and the sampled flag clears.
  - Otherwise the counter increments, saturating at SETTLE_CYC.
  - Capture fires on the cycle where r_enb is legal, counter==SETTLE_CYC and sampled==0. On that edge, sampled is set, so there is exactly one capture per dwell.
- Capture of slot k:
  - shadow[k] <= decode(r_seg);
  - shadow_dp[k] <= r_dp;
  - seen[k] <= 1;
  - err_acc |= (decode==4'hE).
  - Re-capturing a position before the frame completes overwrites it silently.
- Decode table: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9, 0000000->4'hF (blank), any other pattern->4'hE.
- Frame completion: on the edge after seen becomes 6'b111111:
  - o_digits<=shadow, o_dp<=shadow_dp;
  - o_frame_vld=1 and o_frame_err=err_acc for that cycle;
  - seen and err_acc clear.
  - If a capture lands in that same cycle, it is applied to the cleared mask, so it counts toward the next frame.
- Latency: a raw enable change is followed by capture at edge SETTLE_CYC+1. o_frame_vld follows the sixth capture by 1 cycle.
- Outputs other than the pulses hold between frames.
- Scan order is free: any order works, as long as all six positions are seen.
- Reset mid-frame discards partial captures. The first frame after reset requires all six positions again.
- Glitch tolerance: an enable dwell shorter than SETTLE_CYC cycles produces no capture.

Test Plan:
- Ordered scan 0..5, dwell 10 cycles, SETTLE_CYC=4. Slots 0/1 carry 0110000/1111110 and slots 2..5 carry 0000000 -> o_frame_vld once; o_digits=24'hFFFF01; o_dp=0; o_frame_err=0.
- Same scan with slot 3 = 1010101 and dp=1 on slot 5 -> o_digits[15:12]=4'hE, o_frame_err=1, o_dp=6'b100000.
- Slot 2 enabled for only 3 cycles, then the scan continues -> no capture for slot 2 and no o_frame_vld until a full-length slot-2 dwell arrives. The next frame then reports the new slot-2 digit.
- Inject i_seg_enb=6'b111100 for 2 cycles mid-scan -> o_enb_err pulses 2 cycles (one per cycle illegal); that dwell yields no capture. The frame still completes after the remaining slots.
- Assert rst after slots 0..3 are captured, then release and rescan all six -> outputs return to 24'hFFFFFF/0 during reset. Exactly one o_frame_vld follows the full rescan, and no data from before the reset is merged in.
- Two consecutive full scans with different digits (59 then 00 on slots 1/0) -> two o_frame_vld pulses. o_digits[7:0] goes 8'h59 then 8'h00, and every pulse is exactly one cycle wide.
